// File: rtl/regfile_access_seq.sv
// regfile_access_seq
// Initiator-side sequencer for an 8 x 8-bit register file. It accepts one
// register-to-register instruction over a valid/ready handshake, reads the
// operands, computes an ALU result and writes it back, one instruction at a time.
// Every port output is a register, so no input reaches an output combinationally.

module regfile_access_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic [DATA_W-1:0] imm,
  output logic              rd_en1,
  output logic              rd_en2,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rd_out1,
  input  logic [DATA_W-1:0] rd_out2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL1 = 3'b101,
    OP_LDI  = 3'b110,
    OP_MOV  = 3'b111
  } op_e;

  state_e              state;
  op_e                 op_q;        // latched opcode, steers the ALU in EXEC
  logic [ADDR_W-1:0]   dst_q;       // latched destination, loaded into wr_addr in EXEC
  logic                carry_pend;  // carry of the in-flight op, published on retire

  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic [DATA_W:0]     alu_wide;

  // Ops that consume a second source operand (and so use read port 2).
  function automatic logic is_binary(input op_e o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND) ||
           (o == OP_OR)  || (o == OP_XOR);
  endfunction

  // ALU: combinational function of the latched opcode and the read data.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    alu_wide  = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_wide  = {1'b0, rd_out1} + {1'b0, rd_out2};
        alu_res   = alu_wide[DATA_W-1:0];
        alu_carry = alu_wide[DATA_W];
      end
      OP_SUB: begin
        // Bit DATA_W of the widened difference is the unsigned borrow (a < b).
        alu_wide  = {1'b0, rd_out1} - {1'b0, rd_out2};
        alu_res   = alu_wide[DATA_W-1:0];
        alu_carry = alu_wide[DATA_W];
      end
      OP_AND:  alu_res = rd_out1 & rd_out2;
      OP_OR:   alu_res = rd_out1 | rd_out2;
      OP_XOR:  alu_res = rd_out1 ^ rd_out2;
      OP_SHL1: alu_res = {rd_out1[DATA_W-2:0], 1'b0};
      OP_MOV:  alu_res = rd_out1;
      default: alu_res = '0;  // LDI bypasses EXEC entirely
    endcase
  end

  // Sequencer FSM with all port outputs registered alongside the state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_ADD;
      dst_q       <= '0;
      carry_pend  <= 1'b0;
      instr_ready <= 1'b0;
      rd_en1      <= 1'b0;
      rd_en2      <= 1'b0;
      rd_addr1    <= '0;
      rd_addr2    <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      done        <= 1'b0;
      result      <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // instr_ready comes up one cycle after reset release; acceptance
          // only happens while it is already visible to the initiator.
          if (instr_ready && instr_valid) begin
            op_q        <= op_e'(op);
            dst_q       <= dst;
            instr_ready <= 1'b0;
            if (op_e'(op) == OP_LDI) begin
              // The immediate is the write data; no operand read is needed.
              wr_en      <= 1'b1;
              wr_addr    <= dst;
              wr_data    <= imm;
              carry_pend <= 1'b0;
              state      <= S_WRITE;
            end else begin
              rd_en1   <= 1'b1;
              rd_addr1 <= src1;
              rd_en2   <= is_binary(op_e'(op));
              rd_addr2 <= is_binary(op_e'(op)) ? src2 : '0;
              state    <= S_READ;
            end
          end else begin
            instr_ready <= 1'b1;
          end
        end

        S_READ: begin
          // The register file samples the read addresses on this edge.
          rd_en1 <= 1'b0;
          rd_en2 <= 1'b0;
          state  <= S_EXEC;
        end

        S_EXEC: begin
          wr_data    <= alu_res;
          carry_pend <= alu_carry;
          wr_en      <= 1'b1;
          wr_addr    <= dst_q;
          state      <= S_WRITE;
        end

        S_WRITE: begin
          // The register file commits on the negedge inside this cycle, so a
          // dependent instruction accepted in the done cycle reads new data.
          wr_en       <= 1'b0;
          result      <= wr_data;
          carry       <= carry_pend;
          zero        <= (wr_data == '0);
          done        <= 1'b1;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_seq.sv
// tb_regfile_access_seq
// Drives instructions into regfile_access_seq against a behavioural register
// file. Expected writes and flags are predicted from a shadow register model,
// queued on accept, and compared when the sequencer writes and retires.

module tb_regfile_access_seq;

  localparam int DW = 8;
  localparam int AW = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL1 = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_MOV  = 3'b111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    op;
  logic [AW-1:0] dst, src1, src2;
  logic [DW-1:0] imm;
  logic          rd_en1, rd_en2;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic [DW-1:0] rd_out1, rd_out2;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          done;
  logic [DW-1:0] result;
  logic          carry, zero;

  logic [DW-1:0] rf_mem [8];   // behavioural register file contents
  logic [DW-1:0] model  [8];   // shadow of what the registers should hold

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] dst, src1, src2;
    logic [DW-1:0] data;
    logic          c, z;
    int            lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_access_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .dst(dst), .src1(src1), .src2(src2), .imm(imm),
    .rd_en1(rd_en1), .rd_en2(rd_en2), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_out1(rd_out1), .rd_out2(rd_out2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .result(result), .carry(carry), .zero(zero)
  );

  // Register file: reads sampled on posedge, writes committed on negedge.
  always @(posedge clk) begin
    if (rd_en1) rd_out1 <= rf_mem[rd_addr1];
    if (rd_en2) rd_out2 <= rf_mem[rd_addr2];
  end

  always @(negedge clk) begin
    if (wr_en) rf_mem[wr_addr] <= wr_data;
  end

  // Reference behaviour of one instruction given the current shadow registers.
  function automatic exp_t predict(input logic [2:0] o, input logic [AW-1:0] d,
                                   input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                                   input logic [DW-1:0] iv);
    exp_t e;
    int a, b, s;
    a = int'(model[s1]);
    b = int'(model[s2]);
    e.op = o; e.dst = d; e.src1 = s1; e.src2 = s2; e.c = 1'b0;
    e.lat = (o == OP_LDI) ? 1 : 3;
    case (o)
      3'b000: begin s = a + b; e.data = DW'(s % 256); e.c = (s > 255); end
      3'b001: begin s = a - b + 256; e.data = DW'(s % 256); e.c = (a < b); end
      3'b010: e.data = model[s1] & model[s2];
      3'b011: e.data = model[s1] | model[s2];
      3'b100: e.data = model[s1] ^ model[s2];
      3'b101: e.data = DW'((a * 2) % 256);
      3'b110: e.data = iv;
      default: e.data = model[s1];
    endcase
    e.z = (e.data == 8'd0);
    return e;
  endfunction

  // Present one instruction in an IDLE cycle and queue its expected outcome.
  task automatic send(input logic [2:0] o, input logic [AW-1:0] d, input logic [AW-1:0] s1,
                      input logic [AW-1:0] s2, input logic [DW-1:0] iv, input bit hold);
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_ready: instr_ready=%b, expected 1", instr_ready);
    end
    op = o; dst = d; src1 = s1; src2 = s2; imm = iv;
    instr_valid = 1'b1;
    sb_q.push_back(predict(o, d, s1, s2, iv));
    @(negedge clk);
    if (!hold) instr_valid = 1'b0;
  endtask

  // Follow the oldest queued instruction to retirement, checking the ports.
  task automatic retire();
    exp_t e;
    int   cyc;
    int   writes;
    bit   bin;
    e = sb_q[0];
    bin = (e.op <= OP_XOR);
    cyc = 0;
    writes = 0;
    while (done !== 1'b1 && cyc < 12) begin
      n_cmp++;
      if (instr_ready !== 1'b0) begin
        n_err++;
        $display("FAIL busy_ready: cycle %0d instr_ready=%b, expected 0", cyc, instr_ready);
      end
      n_cmp++;
      if (e.lat == 3 && cyc == 0) begin
        if (rd_en1 !== 1'b1 || rd_addr1 !== e.src1 || rd_en2 !== bin ||
            (bin && rd_addr2 !== e.src2)) begin
          n_err++;
          $display("FAIL read_port: en1=%b a1=%0d en2=%b a2=%0d, expected en1=1 a1=%0d en2=%b a2=%0d",
                   rd_en1, rd_addr1, rd_en2, rd_addr2, e.src1, bin, e.src2);
        end
      end else if (rd_en1 !== 1'b0 || rd_en2 !== 1'b0) begin
        n_err++;
        $display("FAIL read_quiet: cycle %0d en1=%b en2=%b, expected 0/0", cyc, rd_en1, rd_en2);
      end
      if (wr_en === 1'b1) begin
        writes++;
        n_cmp++;
        if (cyc != e.lat - 1 || wr_addr !== e.dst || wr_data !== e.data) begin
          n_err++;
          $display("FAIL write_port: cycle %0d addr=%0d data=%0d, expected cycle %0d addr=%0d data=%0d",
                   cyc, wr_addr, wr_data, e.lat - 1, e.dst, e.data);
        end
      end
      @(negedge clk);
      cyc++;
    end
    instr_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL retire_timeout: done=%b after %0d cycles, expected 1", done, cyc);
    end else begin
      n_cmp++;
      if (cyc != e.lat || writes != 1) begin
        n_err++;
        $display("FAIL latency: done at %0d with %0d writes, expected %0d with 1", cyc, writes, e.lat);
      end
      n_cmp++;
      if (result !== e.data || carry !== e.c || zero !== e.z) begin
        n_err++;
        $display("FAIL flags: result=%0d carry=%b zero=%b, expected %0d/%b/%b",
                 result, carry, zero, e.data, e.c, e.z);
      end
      n_cmp++;
      if (rf_mem[e.dst] !== e.data) begin
        n_err++;
        $display("FAIL regfile: r%0d=%0d, expected %0d", e.dst, rf_mem[e.dst], e.data);
      end
      n_cmp++;
      if (instr_ready !== 1'b1) begin
        n_err++;
        $display("FAIL done_ready: instr_ready=%b in done cycle, expected 1", instr_ready);
      end
    end
    model[e.dst] = e.data;
    void'(sb_q.pop_front());
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({instr_ready, rd_en1, rd_en2, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
         done, result, carry, zero} !== '0) begin
      n_err++;
      $display("FAIL %s: ready=%b en=%b%b wr_en=%b wr=%0d/%0d done=%b result=%0d c=%b z=%b, expected all 0",
               tag, instr_ready, rd_en1, rd_en2, wr_en, wr_addr, wr_data, done, result, carry, zero);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: ready=%b done=%b, expected 1/0", instr_ready, done);
    end
  endtask

  task automatic test_ldi();
    send(OP_LDI, 3'd1, 3'd0, 3'd0, 8'd200, 1'b0);
    retire();
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: done=%b one cycle after retire, expected 0", done);
    end
    send(OP_LDI, 3'd2, 3'd0, 3'd0, 8'd100, 1'b0);
    retire();
  endtask

  task automatic test_alu();
    send(OP_ADD, 3'd3, 3'd1, 3'd2, 8'hFF, 1'b0);   // 200+100 -> 44, carry
    retire();
    send(OP_SUB, 3'd4, 3'd2, 3'd1, 8'h00, 1'b0);   // 100-200 -> 156, borrow
    retire();
    send(OP_XOR, 3'd5, 3'd1, 3'd1, 8'h00, 1'b0);   // self-xor -> 0, zero
    retire();
  endtask

  task automatic test_back_to_back();
    send(OP_LDI, 3'd0, 3'd0, 3'd0, 8'd7, 1'b0);
    retire();
    // Accepted in the done cycle of the LDI; valid stays high while busy.
    send(OP_MOV, 3'd6, 3'd0, 3'd3, 8'd0, 1'b1);
    op = OP_LDI; dst = 3'd5; src1 = 3'd4; imm = 8'hEE;
    retire();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (wr_en !== 1'b0 || rd_en1 !== 1'b0 || instr_ready !== 1'b1) begin
        n_err++;
        $display("FAIL no_extra_accept: wr_en=%b rd_en1=%b ready=%b, expected 0/0/1",
                 wr_en, rd_en1, instr_ready);
      end
    end
  endtask

  task automatic test_shl1();
    send(OP_LDI, 3'd7, 3'd0, 3'd0, 8'h81, 1'b0);
    retire();
    send(OP_SHL1, 3'd2, 3'd7, 3'd5, 8'h00, 1'b0);  // 0x81 << 1 -> 0x02
    retire();
  endtask

  task automatic test_reset_mid_op();
    send(OP_ADD, 3'd7, 3'd1, 3'd2, 8'h00, 1'b0);
    @(negedge clk);                                 // now in EXEC
    #1 rst_n = 1'b0;
    #1 check_all_zero("midop_reset");
    sb_q.delete();
    @(negedge clk);
    n_cmp++;
    if (rf_mem[7] !== model[7] || wr_en !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abandoned: r7=%0d wr_en=%b done=%b, expected %0d/0/0",
               rf_mem[7], wr_en, done, model[7]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    send(OP_LDI, 3'd5, 3'd0, 3'd0, 8'h3C, 1'b0);
    retire();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = '0;
      model[i]  = '0;
    end
    rd_out1 = '0; rd_out2 = '0;
    instr_valid = 1'b0;
    op = '0; dst = '0; src1 = '0; src2 = '0; imm = '0;
    test_reset();
    test_ldi();
    test_alu();
    test_back_to_back();
    test_shl1();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_access_seq.md
Name: regfile_access_seq

Overview:
- Initiator-side sequencer that owns the read and write ports of the 8 x 8-bit register file.
- Accepts one register-to-register instruction at a time over a valid/ready handshake.
- Drives the register file read port (rd_en1/rd_en2, rd_addr1/rd_addr2), captures rd_out1/rd_out2, computes an 8-bit ALU result, then drives the write port (wr_en, wr_addr, wr_data).
- Sits between the instruction source/decoder and the register file.

Parameters:
DATA_W, 8, register data width; must match register file width
ADDR_W, 3, register address width (8 registers)

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction present on op/dst/src1/src2/imm
instr_ready  output  1  sequencer can accept an instruction
op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 LDI, 111 MOV
dst  input  ADDR_W  destination register
src1  input  ADDR_W  first source register
src2  input  ADDR_W  second source register (ADD/SUB/AND/OR/XOR only)
imm  input  DATA_W  immediate (LDI only)
rd_en1  output  1  register file read enable 1
rd_en2  output  1  register file read enable 2
rd_addr1  output  ADDR_W  read address 1
rd_addr2  output  ADDR_W  read address 2
rd_out1  input  DATA_W  register file read data 1
rd_out2  input  DATA_W  register file read data 2
wr_en  output  1  register file write enable
wr_addr  output  ADDR_W  write address
wr_data  output  DATA_W  write data
done  output  1  one-cycle pulse: instruction retired
result  output  DATA_W  last value written; holds until next retire
carry  output  1  ADD carry-out / SUB borrow of last retired op; 0 for other ops
zero  output  1  result == 0 for last retired op

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0, including instr_ready, result, carry, zero and the latched instruction fields.
- FSM states: IDLE, READ, EXEC, WRITE. All port outputs are decoded from registered state and fields (Moore); there is no combinational path from any input to any output.
- IDLE: instr_ready=1. On posedge with instr_valid=1:
  - latch op/dst/src1/src2/imm;
  - go to READ, or to WRITE directly for LDI (wr_data=imm).
- READ: instr_ready=0.
  - rd_en1=1, rd_addr1=src1.
  - rd_en2=1 and rd_addr2=src2 for binary ops only; rd_en2=0 for SHL1/MOV.
  - The register file samples on this posedge. Next state EXEC.
- EXEC: read enables 0.
  - Sample rd_out1/rd_out2 and compute with 8-bit wrap.
  - ADD carry = bit 8 of the 9-bit sum. SUB: a-b, carry=1 when a<b (unsigned). SHL1: a<<1, bit0=0, carry=0.
  - MOV passes a. Logic ops set carry=0.
  - Result is registered into wr_data. Next state WRITE.
- WRITE: wr_en=1, wr_addr=dst, wr_data=result for exactly one cycle. The register file commits on the negedge inside this cycle. Next state IDLE.
- The posedge leaving WRITE updates result/carry/zero and pulses done=1 for the following cycle (the first IDLE cycle).
- Latency: 3 cycles accept-to-retire for ALU ops (READ, EXEC, WRITE); 1 cycle for LDI.
- Back-to-back: instr_ready=1 in the same cycle done=1, so a new instruction can be accepted there.
- Hazards: the write commits at the negedge of WRITE, before any following READ, so a dependent instruction reads the new value with no stall.
- Other rules:
  - dst == src1/src2 is legal.
  - instr_valid is ignored outside IDLE.
  - Field changes while not accepted have no effect.
  - The register file's wr_success output is not used.
- Reset mid-operation: immediate return to IDLE, wr_en drops asynchronously, no done pulse. The in-flight instruction is abandoned, and any write already committed stays committed.

Test Plan:
- Reset, then LDI dst=1 imm=200 -> wr_en=1, wr_addr=1, wr_data=200 the cycle after accept; done next cycle; result=200, zero=0.
- With r1=200 and r2=100 loaded, ADD dst=3 src1=1 src2=2 -> rd_en1=rd_en2=1 with addrs 1/2 for one cycle; write r3=44, carry=1, done 3 cycles after accept.
- SUB dst=4 src1=2 src2=1 (100-200) -> r4=156, carry=1. XOR dst=5 src1=1 src2=1 -> r5=0, zero=1, carry=0.
- Back-to-back: LDI r0=7 accepted the cycle done rises, then MOV r6,r0 -> r6=7 with no stall; instr_ready low during READ/EXEC/WRITE; instr_valid held high there causes no extra accept.
- SHL1 src1 = r holding 0x81 -> result 0x02, carry=0, rd_en2=0 throughout.
- Assert rst_n low during EXEC of an ADD -> all outputs 0 immediately, no write or done for that instruction; after release, instr_ready=1 and a new LDI completes normally.
